// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache refill controller:
// address field layout, access-size and FSM encodings, and the line record.
package cache_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int SET_W    = 4;
  localparam int WORDS    = 4;
  localparam int TAG_W    = 8;
  localparam int NUM_SETS = 16;

  // Byte address layout: [15:8] tag, [7:4] set, [3:2] word, [1:0] byte
  localparam int TAG_LSB  = 8;
  localparam int SET_LSB  = 4;
  localparam int WORD_LSB = 2;

  typedef enum logic [1:0] {
    DT_WORD = 2'b00,
    DT_BYTE = 2'b01,
    DT_HALF = 2'b10
  } dtype_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REFILL = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  typedef struct packed {
    logic                         valid;
    logic [TAG_W-1:0]             tag;
    logic [WORDS-1:0][DATA_W-1:0] word;
  } line_t;

endpackage

// File: rtl/cache_byte_merge.sv
// Store lane logic: turns access size and low address bits into byte-lane
// enables, replicates narrow store data across the lanes, and merges the
// enabled lanes into an existing word (other lanes keep their old bytes).
// Access size 2'b11 behaves as a full word.
module cache_byte_merge
  import cache_pkg::*;
(
  input  logic [1:0]        dtype,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] old_word,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] merged_word
);

  // Lane enables, replicated data and the merged result
  always_comb begin
    wstrb       = 4'b1111;
    wdata_rep   = wdata;
    merged_word = old_word;
    case (dtype_e'(dtype))
      DT_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      DT_HALF: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = wstrb[i] ? wdata_rep[8*i +: 8] : old_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped data cache controller (16 sets x 4-word lines, write-through,
// no write-allocate). Serves load hits from local storage, refills a whole
// line over the req/ack memory port on a load miss, and forwards every store
// to memory, updating the cached word when the store hits.
// Optional build macro CRITICAL_WORD_FIRST_EN: a refill starts at the
// requested word and wraps; otherwise beats go 0,1,2,3.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int SET_ADDR_WIDTH = SET_W,
  parameter int WORDS_PER_LINE = WORDS
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [1:0]            cpu_dtype,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  miss
);

  localparam int LINES = 2 ** SET_ADDR_WIDTH;

  line_t                     lines_r [0:LINES-1];
  state_e                    state_r, next_state_s;
  logic [1:0]                beat_r, beat_nxt_s;
  logic [1:0]                cnt_r, cnt_nxt_s;

  logic                      cpu_ack_r, cpu_ack_nxt_s;
  logic [DATA_WIDTH-1:0]     cpu_rdata_r, cpu_rdata_nxt_s;
  logic                      mem_req_r, mem_req_nxt_s;
  logic                      mem_we_r, mem_we_nxt_s;
  logic [ADDR_WIDTH-1:0]     mem_addr_r, mem_addr_nxt_s;
  logic [DATA_WIDTH-1:0]     mem_wdata_r, mem_wdata_nxt_s;
  logic [3:0]                mem_wstrb_r, mem_wstrb_nxt_s;
  logic                      miss_r, miss_nxt_s;

  // Fields of the request accepted in IDLE, held for the whole access
  logic [TAG_W-1:0]          req_tag_r;
  logic [SET_ADDR_WIDTH-1:0] req_set_r;
  logic [1:0]                req_word_r;
  logic [1:0]                req_blo_r;
  logic [1:0]                req_dtype_r;
  logic [DATA_WIDTH-1:0]     req_wdata_r;
  logic                      req_hit_r;

  logic [TAG_W-1:0]          tag_in_s;
  logic [SET_ADDR_WIDTH-1:0] set_in_s;
  logic [1:0]                word_in_s;
  logic [1:0]                start_beat_s;
  logic                      hit_s;
  logic                      accept_s;

  logic                      clr_valid_s, fill_we_s, fill_last_s, hit_upd_s;

  logic                      idle_s;
  logic [1:0]                mrg_dtype_s, mrg_blo_s;
  logic [DATA_WIDTH-1:0]     mrg_wdata_s, mrg_old_s;
  logic [3:0]                mrg_wstrb_s;
  logic [DATA_WIDTH-1:0]     mrg_rep_s, mrg_word_s;

  assign tag_in_s  = cpu_addr[ADDR_WIDTH-1:TAG_LSB];
  assign set_in_s  = cpu_addr[SET_LSB +: SET_ADDR_WIDTH];
  assign word_in_s = cpu_addr[WORD_LSB +: 2];
  assign hit_s     = lines_r[set_in_s].valid && (lines_r[set_in_s].tag == tag_in_s);
  assign idle_s    = (state_r == ST_IDLE);
  assign accept_s  = idle_s && cpu_req;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_beat_s = word_in_s;
`else
  assign start_beat_s = 2'd0;
`endif

  // The merge unit sees the live request when building the store in IDLE,
  // and the held request when updating the cached word on the write ack.
  assign mrg_dtype_s = idle_s ? cpu_dtype      : req_dtype_r;
  assign mrg_blo_s   = idle_s ? cpu_addr[1:0]  : req_blo_r;
  assign mrg_wdata_s = idle_s ? cpu_wdata      : req_wdata_r;
  assign mrg_old_s   = lines_r[req_set_r].word[req_word_r];

  cache_byte_merge u_merge (
    .dtype       (mrg_dtype_s),
    .addr_lo     (mrg_blo_s),
    .wdata       (mrg_wdata_s),
    .old_word    (mrg_old_s),
    .wstrb       (mrg_wstrb_s),
    .wdata_rep   (mrg_rep_s),
    .merged_word (mrg_word_s)
  );

  // Next state, next registered outputs and storage update strobes
  always_comb begin
    next_state_s    = state_r;
    beat_nxt_s      = beat_r;
    cnt_nxt_s       = cnt_r;
    cpu_rdata_nxt_s = cpu_rdata_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    mem_wstrb_nxt_s = mem_wstrb_r;
    clr_valid_s     = 1'b0;
    fill_we_s       = 1'b0;
    fill_last_s     = 1'b0;
    hit_upd_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            next_state_s    = ST_WRITE;
            mem_req_nxt_s   = 1'b1;
            mem_we_nxt_s    = 1'b1;
            mem_addr_nxt_s  = {cpu_addr[ADDR_WIDTH-1:WORD_LSB], 2'b00};
            mem_wdata_nxt_s = mrg_rep_s;
            mem_wstrb_nxt_s = mrg_wstrb_s;
          end else if (hit_s) begin
            next_state_s    = ST_RESP;
            cpu_rdata_nxt_s = lines_r[set_in_s].word[word_in_s];
          end else begin
            next_state_s    = ST_REFILL;
            clr_valid_s     = 1'b1;
            beat_nxt_s      = start_beat_s;
            cnt_nxt_s       = 2'd0;
            mem_req_nxt_s   = 1'b1;
            mem_we_nxt_s    = 1'b0;
            mem_wstrb_nxt_s = 4'b0000;
            mem_addr_nxt_s  = {cpu_addr[ADDR_WIDTH-1:SET_LSB], start_beat_s, 2'b00};
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REFILL: begin
        if (mem_req_r) begin
          if (mem_ack) begin
            fill_we_s     = 1'b1;
            mem_req_nxt_s = 1'b0;
            if (cnt_r == 2'(WORDS_PER_LINE - 1)) begin
              fill_last_s     = 1'b1;
              next_state_s    = ST_RESP;
              cpu_rdata_nxt_s = (beat_r == req_word_r) ? mem_rdata
                                                       : lines_r[req_set_r].word[req_word_r];
            end else begin
              beat_nxt_s = beat_r + 2'd1;
              cnt_nxt_s  = cnt_r + 2'd1;
            end
          end else begin
            mem_req_nxt_s = 1'b1;
          end
        end else begin
          // Gap cycle after an ack: issue the next beat
          mem_req_nxt_s  = 1'b1;
          mem_addr_nxt_s = {req_tag_r, req_set_r, beat_r, 2'b00};
        end
      end
      ST_WRITE: begin
        if (mem_req_r && mem_ack) begin
          next_state_s    = ST_RESP;
          mem_req_nxt_s   = 1'b0;
          mem_we_nxt_s    = 1'b0;
          mem_wstrb_nxt_s = 4'b0000;
          hit_upd_s       = req_hit_r;
          cpu_rdata_nxt_s = req_hit_r ? mrg_word_s : cpu_rdata_r;
        end else begin
          next_state_s = ST_WRITE;
        end
      end
      ST_RESP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s  = ST_IDLE;
        mem_req_nxt_s = 1'b0;
        mem_we_nxt_s  = 1'b0;
      end
    endcase
    cpu_ack_nxt_s = (next_state_s == ST_RESP);
    miss_nxt_s    = (next_state_s == ST_REFILL);
  end

  // State, beat counter, registered outputs and accepted-request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      beat_r      <= 2'd0;
      cnt_r       <= 2'd0;
      cpu_ack_r   <= 1'b0;
      cpu_rdata_r <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wstrb_r <= 4'b0000;
      miss_r      <= 1'b0;
      req_tag_r   <= '0;
      req_set_r   <= '0;
      req_word_r  <= 2'd0;
      req_blo_r   <= 2'd0;
      req_dtype_r <= 2'd0;
      req_wdata_r <= '0;
      req_hit_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      beat_r      <= beat_nxt_s;
      cnt_r       <= cnt_nxt_s;
      cpu_ack_r   <= cpu_ack_nxt_s;
      cpu_rdata_r <= cpu_rdata_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_wstrb_r <= mem_wstrb_nxt_s;
      miss_r      <= miss_nxt_s;
      if (accept_s) begin
        req_tag_r   <= tag_in_s;
        req_set_r   <= set_in_s;
        req_word_r  <= word_in_s;
        req_blo_r   <= cpu_addr[1:0];
        req_dtype_r <= cpu_dtype;
        req_wdata_r <= cpu_wdata;
        req_hit_r   <= hit_s;
      end
    end
  end

  // Line storage: invalidate on miss, fill beats, tag on last beat, store-hit merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) begin
        lines_r[i] <= '0;
      end
    end else begin
      if (clr_valid_s) begin
        lines_r[set_in_s].valid <= 1'b0;
      end
      if (fill_we_s) begin
        lines_r[req_set_r].word[beat_r] <= mem_rdata;
      end
      if (fill_last_s) begin
        lines_r[req_set_r].tag   <= req_tag_r;
        lines_r[req_set_r].valid <= 1'b1;
      end
      if (hit_upd_s) begin
        lines_r[req_set_r].word[req_word_r] <= mrg_word_s;
      end
    end
  end

  assign cpu_ack   = cpu_ack_r;
  assign cpu_rdata = cpu_rdata_r;
  assign cpu_stall = rst_n & cpu_req & ~cpu_ack_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;
  assign miss      = miss_r;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a reference model (tag table plus a
// byte-array RAM image) predicts every CPU response and memory transaction;
// a memory responder and a CPU-side monitor pop and compare independently.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_dtype;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        miss;

  cache_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_dtype(cpu_dtype), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .miss(miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } mem_txn_t;

  typedef struct {
    logic        we;
    logic        hit;
    logic [31:0] rdata;
  } resp_t;

  mem_txn_t    mem_exp[$];
  resp_t       sb[$];

  int          errors = 0;
  int          checks = 0;
  int          ack_cnt = 0;

  logic [7:0]  ref_ram [0:65535];
  logic [31:0] env_ram [0:16383];
  bit          ref_valid [0:15];
  logic [7:0]  ref_tag [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    int b;
    b = int'({a[15:2], 2'b00});
    return {ref_ram[b+3], ref_ram[b+2], ref_ram[b+1], ref_ram[b]};
  endfunction

  // Reference model: predict memory traffic and CPU response, then run the access
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [1:0] dt,
                           input logic [31:0] wd);
    int       set, base;
    logic     hit;
    logic [1:0] start;
    logic [3:0] strb;
    logic [31:0] data;
    mem_txn_t t;
    resp_t    r;
    bit       got;
    set  = int'(addr[7:4]);
    hit  = ref_valid[set] && (ref_tag[set] == addr[15:8]);
    base = int'({addr[15:2], 2'b00});
    if (!we) begin
      if (!hit) begin
`ifdef CRITICAL_WORD_FIRST_EN
        start = addr[3:2];
`else
        start = 2'd0;
`endif
        for (int k = 0; k < 4; k++) begin
          t.we = 1'b0; t.strb = 4'b0000; t.wdata = 32'h0;
          t.addr = {addr[15:4], 2'(start + 2'(k)), 2'b00};
          mem_exp.push_back(t);
        end
        ref_valid[set] = 1'b1;
        ref_tag[set]   = addr[15:8];
      end
      r.rdata = ref_word(addr);
    end else begin
      case (dt)
        2'b01:   begin strb = 4'b0001 << addr[1:0]; data = {4{wd[7:0]}}; end
        2'b10:   begin strb = addr[1] ? 4'b1100 : 4'b0011; data = {2{wd[15:0]}}; end
        default: begin strb = 4'b1111; data = wd; end
      endcase
      t.we = 1'b1; t.addr = 16'(base); t.strb = strb; t.wdata = data;
      mem_exp.push_back(t);
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) ref_ram[base+i] = data[8*i +: 8];
      end
      r.rdata = 32'h0;
    end
    r.we = we; r.hit = hit;
    sb.push_back(r);
    @(posedge clk); #2;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_dtype = dt; cpu_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cpu_ack) begin got = 1'b1; break; end
    end
    chk("access_completed", 32'(got), 32'd1);
    chk("mem_traffic_drained", 32'(mem_exp.size()), 32'd0);
    @(posedge clk); #2;
    cpu_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_miss"},      32'(miss),      32'd0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata,      32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
  endtask

  // Memory responder: checks each new request against the expected queue, acks after a random delay
  initial begin
    bit          busy;
    int          dly;
    logic [15:0] a;
    mem_txn_t    e;
    busy = 1'b0; dly = 0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; mem_ack = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0; busy = 1'b0;
      end else begin
        if (!busy && mem_req) begin
          busy = 1'b1;
          dly  = int'($urandom_range(0, 3));
          if (mem_exp.size() == 0) begin
            chk("unexpected_mem_req", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            e = mem_exp.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            if (e.we) begin
              chk("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
              chk("mem_wdata", mem_wdata, e.wdata);
            end else begin
              chk("miss_during_refill", 32'(miss), 32'd1);
            end
          end
        end
        if (busy) begin
          if (dly == 0) begin
            a = mem_addr;
            mem_ack = 1'b1;
            mem_rdata = env_ram[a[15:2]];
            if (mem_we) begin
              for (int i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) env_ram[a[15:2]][8*i +: 8] = mem_wdata[8*i +: 8];
              end
            end
            ack_cnt++;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // CPU-side monitor: stall relation every cycle, response data and latency on each ack
  initial begin
    int    stall_n, miss_n;
    resp_t r;
    stall_n = 0; miss_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_n = 0; miss_n = 0;
      end else begin
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_ack));
        if (miss) miss_n++;
        if (cpu_ack) begin
          if (sb.size() == 0) begin
            chk("unexpected_cpu_ack", 32'(cpu_ack), 32'd0);
          end else begin
            r = sb.pop_front();
            if (!r.we) begin
              chk("cpu_rdata", cpu_rdata, r.rdata);
              if (r.hit) begin
                chk("load_hit_latency", 32'(stall_n), 32'd1);
                chk("no_miss_on_hit", 32'(miss_n), 32'd0);
              end else begin
                chk("miss_cycles_ge4", 32'(miss_n >= 4), 32'd1);
              end
            end else begin
              chk("no_miss_on_store", 32'(miss_n), 32'd0);
            end
          end
          stall_n = 0; miss_n = 0;
        end else if (cpu_req) begin
          stall_n++;
        end
      end
    end
  end

  // Main stimulus: directed scenario, mid-refill reset, then randomized traffic
  initial begin
    logic [31:0] w;
    int          base;
    bit          reached;
    mem_txn_t    t;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0; cpu_dtype = 2'b00;
    for (int i = 0; i < 16384; i++) begin
      w = $urandom();
      if (i >= 16'h0040 && i <= 16'h0043) w = 32'h0000_00A0 + 32'(i - 16'h0040);
      env_ram[i] = w;
      for (int b = 0; b < 4; b++) ref_ram[4*i+b] = w[8*b +: 8];
    end
    for (int s = 0; s < 16; s++) begin ref_valid[s] = 1'b0; ref_tag[s] = 8'h00; end

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    do_access(1'b0, 16'h0104, 2'b00, 32'h0);
    do_access(1'b0, 16'h010C, 2'b00, 32'h0);
    do_access(1'b1, 16'h0105, 2'b01, 32'h0000_00EE);
    do_access(1'b0, 16'h0104, 2'b00, 32'h0);
    chk("byte_merge_result", ref_word(16'h0104), 32'h0000_EEA1);
    do_access(1'b1, 16'h0106, 2'b10, 32'h0000_5A3C);
    do_access(1'b0, 16'h0104, 2'b00, 32'h0);
    do_access(1'b1, 16'h0108, 2'b11, 32'h1234_5678);
    do_access(1'b0, 16'h0108, 2'b00, 32'h0);
    do_access(1'b0, 16'h0204, 2'b00, 32'h0);
    do_access(1'b0, 16'h0100, 2'b00, 32'h0);
    do_access(1'b1, 16'h0F30, 2'b00, 32'hCAFE_F00D);
    do_access(1'b0, 16'h0F30, 2'b00, 32'h0);

    // Reset during a refill, after the second beat has been taken
    base = ack_cnt;
    for (int k = 0; k < 4; k++) begin
      t.we = 1'b0; t.strb = 4'b0000; t.wdata = 32'h0;
`ifdef CRITICAL_WORD_FIRST_EN
      t.addr = {12'h030, 2'(2'd1 + 2'(k)), 2'b00};
`else
      t.addr = {12'h030, 2'(k), 2'b00};
`endif
      mem_exp.push_back(t);
    end
    @(posedge clk); #2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0304; cpu_dtype = 2'b00;
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack_cnt >= base + 2) begin reached = 1'b1; break; end
    end
    chk("reset_point_reached", 32'(reached), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    mem_exp.delete();
    sb.delete();
    for (int s = 0; s < 16; s++) ref_valid[s] = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_refill_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b0, 16'h0104, 2'b00, 32'h0);
    do_access(1'b0, 16'h0304, 2'b00, 32'h0);

    // Randomized traffic over a few tags so hits, evictions and write hits mix
    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      logic        we;
      a  = {8'(32'($urandom_range(1, 3))), 4'($urandom()), 4'($urandom())};
      we = ($urandom_range(0, 9) < 3);
      do_access(we, a, 2'($urandom()), $urandom());
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("mem_queue_empty", 32'(mem_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
